// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction-fetch stage of the 16-bit five-stage pipeline.
// Keeps the fetch PC and has at most one request outstanding to a
// variable-latency instruction memory. It loads the IF/ID register with the
// instruction, its PC+2 and a valid bit.
//
// Handshake contract:
// - imem_req is a one-cycle pulse, and imem_addr is valid with it.
// - imem_vld pulses exactly once per request, at least one cycle later.
//   imem_data is valid with that pulse.
// - Decode takes the IF/ID entry in any cycle with if_valid=1 and stall=0.
//   While stall=1, IF/ID holds its contents.
// - A response that arrives during stall with a live IF/ID entry parks in a
//   one-entry skid buffer (state HOLD) until stall falls.
// - redirect has the highest priority. An outstanding response becomes stale
//   (kill) and is dropped when it arrives.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_vld,
  input  logic [15:0] imem_data,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  output logic        if_valid,
  output logic [15:0] pc,
  output logic        fetch_halted,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t      state_q;
  logic        kill_q;
  logic [15:0] pc_q;
  logic [15:0] if_instr_q;
  logic [15:0] if_pc2_q;
  logic        if_valid_q;
  logic [15:0] skid_instr_q;
  logic [15:0] skid_pc2_q;
  logic        halted_q;

  logic [15:0] pc_plus2;
  logic        rsp_hlt;
  logic        skid_hlt;

  // PC increment (16-bit wrap) and HLT opcode detection on the incoming and
  // the buffered instruction.
  always_comb begin
    pc_plus2 = pc_q + 16'd2;
    rsp_hlt  = (imem_data[15:12] == OP_HLT);
    skid_hlt = (skid_instr_q[15:12] == OP_HLT);
  end

  // Fetch FSM, PC, kill flag, skid buffer and the IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ISSUE;
      kill_q       <= 1'b0;
      pc_q         <= RESET_PC;
      if_instr_q   <= 16'h0000;
      if_pc2_q     <= 16'h0000;
      if_valid_q   <= 1'b0;
      skid_instr_q <= 16'h0000;
      skid_pc2_q   <= 16'h0000;
      halted_q     <= 1'b0;
    end else if (redirect) begin
      // Redirect flushes IF/ID, abandons the skid entry and leaves HALT.
      pc_q       <= redirect_pc;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      case (state_q)
        ST_ISSUE: begin
          // The request issued this cycle is now stale.
          state_q <= ST_WAIT;
          kill_q  <= 1'b1;
        end
        ST_WAIT: begin
          if (imem_vld) begin
            // The response arriving now is dropped, so nothing is pending.
            state_q <= ST_ISSUE;
            kill_q  <= 1'b0;
          end else begin
            kill_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_ISSUE;
          kill_q  <= 1'b0;
        end
      endcase
    end else begin
      // Decode consumes the entry whenever it is not stalling. A load below
      // overrides this clear.
      if (!stall) begin
        if_valid_q <= 1'b0;
      end
      case (state_q)
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_vld) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= ST_ISSUE;
            end else if (!stall || !if_valid_q) begin
              if_instr_q <= imem_data;
              if_pc2_q   <= pc_plus2;
              if_valid_q <= 1'b1;
              pc_q       <= pc_plus2;
              halted_q   <= rsp_hlt;
              state_q    <= rsp_hlt ? ST_HALT : ST_ISSUE;
            end else begin
              skid_instr_q <= imem_data;
              skid_pc2_q   <= pc_plus2;
              pc_q         <= pc_plus2;
              state_q      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            if_instr_q <= skid_instr_q;
            if_pc2_q   <= skid_pc2_q;
            if_valid_q <= 1'b1;
            halted_q   <= skid_hlt;
            state_q    <= skid_hlt ? ST_HALT : ST_ISSUE;
          end
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign imem_req     = rst_n && (state_q == ST_ISSUE);
  assign imem_addr    = pc_q;
  assign if_instr     = if_instr_q;
  assign if_pc_plus2  = if_pc2_q;
  assign if_valid     = if_valid_q;
  assign pc           = pc_q;
  assign fetch_halted = halted_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// Bench for fetch_stage.
// A behavioural memory answers each request after mem_lat cycles with
// 16'hA000+addr, or with 16'hF000 at halt_addr. Tests push the
// {instr, pc_plus2} pairs that decode should receive. tick() pops and
// compares one pair whenever decode takes an entry (if_valid=1, stall=0).
module tb_fetch_stage;

  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_vld;
  logic [15:0] imem_data;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic        if_valid;
  logic [15:0] pc;
  logic        fetch_halted;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];

  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [15:0] mem_addr = 16'h0000;
  logic        halt_en = 1'b0;
  logic [15:0] halt_addr = 16'h0000;
  logic        mem_ignore_rst = 1'b0;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_vld     (imem_vld),
    .imem_data    (imem_data),
    .if_instr     (if_instr),
    .if_pc_plus2  (if_pc_plus2),
    .if_valid     (if_valid),
    .pc           (pc),
    .fetch_halted (fetch_halted),
    .dbg_state    (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hF000;
    return 16'hA000 + a;
  endfunction

  // Memory model: samples at the falling edge. Each response is driven for
  // the following rising edge.
  initial begin
    imem_vld  = 1'b0;
    imem_data = 16'h0000;
    forever begin
      @(negedge clk);
      imem_vld = 1'b0;
      if (!rst_n && !mem_ignore_rst) begin
        mem_cnt = 0;
      end else begin
        if (mem_cnt > 0) begin
          mem_cnt = mem_cnt - 1;
          if (mem_cnt == 0) begin
            imem_vld  = 1'b1;
            imem_data = mem_word(mem_addr);
          end
        end
        if (imem_req) begin
          mem_addr = imem_addr;
          mem_cnt  = mem_lat;
        end
      end
    end
  end

  // Finishes the current cycle and takes the IF/ID entry from the
  // scoreboard if decode consumes it. Ends 1 ns after the next falling edge.
  task automatic tick();
    logic [31:0] exp_v;
    if (rst_n && if_valid && !stall) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL consume: got instr %h pc_plus2 %h, required none", if_instr, if_pc_plus2);
      end else begin
        exp_v = exp_q.pop_front();
        if ({if_instr, if_pc_plus2} !== exp_v)
          $display("FAIL consume: got %h/%h required %h/%h", if_instr, if_pc_plus2, exp_v[31:16], exp_v[15:0]);
        else
          n_pass++;
      end
    end
    @(negedge clk);
    #1;
  endtask

  // Driver: reset and release just after a rising edge, so the first
  // request cycle is cycle 0 of the next test.
  task automatic do_reset();
    stall    = 1'b0;
    redirect = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    @(negedge clk); @(negedge clk); #1;
    n_checks++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h required 0000", pc); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", if_valid); else n_pass++;
    n_checks++; if (if_instr !== 16'h0000) $display("FAIL reset_instr: got %h required 0000", if_instr); else n_pass++;
    n_checks++; if (if_pc_plus2 !== 16'h0000) $display("FAIL reset_pc2: got %h required 0000", if_pc_plus2); else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b required 0", imem_req); else n_pass++;
    n_checks++; if (fetch_halted !== 1'b0) $display("FAIL reset_halted: got %b required 0", fetch_halted); else n_pass++;
    n_checks++; if (dbg_state !== S_ISSUE) $display("FAIL reset_state: got %0d required %0d", dbg_state, S_ISSUE); else n_pass++;
  endtask

  task automatic test_fetch();
    mem_lat = 1;
    do_reset();
    exp_q.push_back({16'hA000, 16'h0002});
    exp_q.push_back({16'hA002, 16'h0004});
    exp_q.push_back({16'hA004, 16'h0006});
    exp_q.push_back({16'h9FFC, 16'hFFFE});
    exp_q.push_back({16'h9FFE, 16'h0000});
    // c0
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) $display("FAIL fetch_req0: got %b/%h required 1/0000", imem_req, imem_addr); else n_pass++;
    tick();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL fetch_wait_req: got %b required 0", imem_req); else n_pass++;
    tick();
    n_checks++; if ({if_valid, imem_req, imem_addr} !== {1'b1, 1'b1, 16'h0002}) $display("FAIL fetch_req2: got %b/%b/%h required 1/1/0002", if_valid, imem_req, imem_addr); else n_pass++;
    tick(); tick();
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0004}) $display("FAIL fetch_req4: got %b/%h required 1/0004", imem_req, imem_addr); else n_pass++;
    tick(); tick();
    // c6: redirect while issuing 0x0006 to approach the wrap point
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    tick();
    redirect = 1'b0;
    n_checks++; if ({if_valid, imem_req} !== 2'b00) $display("FAIL wrap_flush: got valid %b req %b required 0/0", if_valid, imem_req); else n_pass++;
    tick();
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 16'hFFFC}) $display("FAIL wrap_reqfffc: got %b/%h required 1/fffc", imem_req, imem_addr); else n_pass++;
    tick(); tick();
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 16'hFFFE}) $display("FAIL wrap_reqfffe: got %b/%h required 1/fffe", imem_req, imem_addr); else n_pass++;
    tick(); tick();
    n_checks++; if ({pc, imem_req, imem_addr} !== {16'h0000, 1'b1, 16'h0000}) $display("FAIL wrap_pc: got pc %h req %b addr %h required 0000/1/0000", pc, imem_req, imem_addr); else n_pass++;
    tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL fetch_drain: got %0d left required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_stall();
    mem_lat = 3;
    do_reset();
    exp_q.push_back({16'hA000, 16'h0002});
    exp_q.push_back({16'hA002, 16'h0004});
    tick(); tick(); tick(); tick();
    // c4
    n_checks++; if (if_valid !== 1'b1) $display("FAIL stall_l3_valid: got %b required 1", if_valid); else n_pass++;
    stall = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({if_valid, if_instr, if_pc_plus2} !== {1'b1, 16'hA000, 16'h0002})
        $display("FAIL stall_hold%0d: got %b/%h/%h required 1/a000/0002", i, if_valid, if_instr, if_pc_plus2);
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if ({dbg_state, imem_req, pc} !== {S_HOLD, 1'b0, 16'h0004})
          $display("FAIL stall_skid: got state %0d req %b pc %h required 2/0/0004", dbg_state, imem_req, pc);
        else n_pass++;
      end
      tick();
    end
    // c9: stall falls
    stall = 1'b0;
    tick();
    n_checks++; if ({if_valid, if_instr, if_pc_plus2} !== {1'b1, 16'hA002, 16'h0004}) $display("FAIL stall_release: got %b/%h/%h required 1/a002/0004", if_valid, if_instr, if_pc_plus2); else n_pass++;
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0004}) $display("FAIL stall_nextreq: got %b/%h required 1/0004", imem_req, imem_addr); else n_pass++;
    tick();
    n_checks++; if (if_valid !== 1'b0) $display("FAIL stall_consumed: got %b required 0", if_valid); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL stall_drain: got %0d left required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    mem_lat = 4;
    do_reset();
    exp_q.push_back({16'hA100, 16'h0102});
    tick(); tick();
    // c2: in WAIT with nothing back yet
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    n_checks++; if ({if_valid, imem_req, dbg_state, pc} !== {1'b0, 1'b0, S_WAIT, 16'h0100}) $display("FAIL rdw_kill: got %b/%b/%0d/%h required 0/0/1/0100", if_valid, imem_req, dbg_state, pc); else n_pass++;
    tick();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rdw_stale_req: got %b required 0", imem_req); else n_pass++;
    tick();
    n_checks++; if ({imem_req, imem_addr, if_valid} !== {1'b1, 16'h0100, 1'b0}) $display("FAIL rdw_newreq: got %b/%h/%b required 1/0100/0", imem_req, imem_addr, if_valid); else n_pass++;
    tick(); tick(); tick(); tick(); tick();
    // c10
    n_checks++; if (if_valid !== 1'b1) $display("FAIL rdw_deliver: got %b required 1", if_valid); else n_pass++;
    tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL rdw_drain: got %0d left required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_redirect_vld();
    mem_lat = 2;
    do_reset();
    exp_q.push_back({16'hA200, 16'h0202});
    tick(); tick(); tick();
    // c3: entry for 0x0000 is live; decode stalls on it
    stall = 1'b1;
    tick(); tick();
    // c5: response for 0x0002 arrives with redirect and stall
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0; stall = 1'b0;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL rdv_flush: got %b required 0", if_valid); else n_pass++;
    n_checks++; if ({imem_req, imem_addr, dbg_state} !== {1'b1, 16'h0200, S_ISSUE}) $display("FAIL rdv_req: got %b/%h/%0d required 1/0200/0", imem_req, imem_addr, dbg_state); else n_pass++;
    tick(); tick(); tick(); tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL rdv_drain: got %0d left required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_halt();
    int reqs;
    mem_lat = 1;
    halt_en = 1'b1; halt_addr = 16'h0004;
    do_reset();
    exp_q.push_back({16'hA000, 16'h0002});
    exp_q.push_back({16'hA002, 16'h0004});
    exp_q.push_back({16'hF000, 16'h0006});
    exp_q.push_back({16'hA040, 16'h0042});
    for (int i = 0; i < 6; i++) tick();
    // c6
    n_checks++; if ({fetch_halted, dbg_state, pc} !== {1'b1, S_HALT, 16'h0006}) $display("FAIL halt_enter: got %b/%0d/%h required 1/3/0006", fetch_halted, dbg_state, pc); else n_pass++;
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) reqs++;
      tick();
    end
    n_checks++; if (reqs != 0) $display("FAIL halt_noreq: got %0d requests required 0", reqs); else n_pass++;
    n_checks++; if (fetch_halted !== 1'b1) $display("FAIL halt_stays: got %b required 1", fetch_halted); else n_pass++;
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    n_checks++; if ({fetch_halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0040}) $display("FAIL halt_resume: got %b/%b/%h required 0/1/0040", fetch_halted, imem_req, imem_addr); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL halt_drain: got %0d left required 0", exp_q.size()); else n_pass++;
    halt_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_lat = 4;
    do_reset();
    mem_ignore_rst = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    // c5: hold the entry so IF/ID is non-zero when reset hits
    stall = 1'b1;
    tick();
    // c6: in WAIT for 0x0002
    rst_n = 1'b0;
    #1;
    n_checks++; if ({pc, if_valid, imem_req, fetch_halted} !== {16'h0000, 1'b0, 1'b0, 1'b0}) $display("FAIL rmid_ctl: got %h/%b/%b/%b required 0000/0/0/0", pc, if_valid, imem_req, fetch_halted); else n_pass++;
    n_checks++; if ({if_instr, if_pc_plus2} !== 32'h0) $display("FAIL rmid_ifid: got %h/%h required 0000/0000", if_instr, if_pc_plus2); else n_pass++;
    n_checks++; if (dbg_state !== S_ISSUE) $display("FAIL rmid_state: got %0d required 0", dbg_state); else n_pass++;
    stall = 1'b0;
    tick(); tick();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    // c9: first request, the stale response is on the bus this cycle
    exp_q.push_back({16'hA000, 16'h0002});
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) $display("FAIL rmid_req: got %b/%h required 1/0000", imem_req, imem_addr); else n_pass++;
    tick();
    n_checks++; if ({if_valid, dbg_state} !== {1'b0, S_WAIT}) $display("FAIL rmid_late: got %b/%0d required 0/1", if_valid, dbg_state); else n_pass++;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL rmid_drain: got %0d left required 0", exp_q.size()); else n_pass++;
    mem_ignore_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_vld();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
